pwm_update_scheduler: RTL and testbench
=======================================

Name: pwm_update_scheduler

Overview:
Sits between the PWM parameter-decode block and the per-channel PWM generators. Captures each decoded configuration (channel, enable, period count, high-level count) into per-channel shadow registers. Transfers each shadow set to that channel's active registers only at a safe point, so a running waveform never sees a partial or mid-period parameter change. Disable requests and configurations for stopped channels apply immediately.

Parameters:
CH_NUM, 8, number of PWM channels served (1..32)
CNT_W, 28, width of period and high-level counts

Ports:
clk  in  1  module clock
rst  in  1  asynchronous active-high reset
pwm_config_vld  in  1  single-cycle strobe; config fields valid
pwm_config_channel  in  8  target channel index
pwm_en  in  1  requested output enable
pwm_period  in  CNT_W  clocks per PWM period
pwm_hlevel  in  CNT_W  clocks of high level per period
ch_cycle_end  in  CH_NUM  per-channel pulse from generator on last clock of its period
ch_load  out  CH_NUM  per-channel 1-cycle strobe; active values just updated
ch_en  out  CH_NUM  active enable per channel
ch_period  out  CH_NUM*CNT_W  active period, channel i at [i*CNT_W +: CNT_W]
ch_hlevel  out  CH_NUM*CNT_W  active high count, same packing
cfg_pending  out  CH_NUM  shadow holds a config not yet applied
cfg_drop  out  1  1-cycle pulse: config for channel index >= CH_NUM discarded
cfg_overwrite  out  1  1-cycle pulse: pending config replaced before it was applied

Behaviour:
- Reset (async, rst=1): all outputs 0; shadow registers 0; every channel FSM returns to IDLE. Any pending config is lost.
- Per-channel FSM has two states:
  - IDLE: no pending config.
  - PEND: shadow holds a config awaiting a safe point.
- Accepting a config:
  - vld at cycle T with channel < CH_NUM writes the shadow at the end of T.
  - vld with channel >= CH_NUM: nothing is written; cfg_drop=1 in T+1.
- Immediate apply, taken at the end of T, so ch_load[i]=1 and the new active values are visible in T+1; FSM stays/returns to IDLE. Applies when either:
  - the active ch_en[i]=0 (channel stopped), or
  - the incoming pwm_en=0 (disable is never deferred).
- Deferred apply: otherwise the FSM goes IDLE->PEND and cfg_pending[i]=1 from T+1.
  - In PEND, ch_cycle_end[i]=1 at cycle C copies shadow to active at the end of C.
  - ch_load[i]=1 in C+1; FSM returns to IDLE and cfg_pending[i]=0 in C+1.
- vld for channel i in PEND (no cycle_end that cycle, and not an immediate-apply case): shadow is overwritten, FSM stays in PEND, cfg_overwrite=1 next cycle. Only the latest config is ever applied.
- vld and ch_cycle_end[i] in the same cycle for channel i:
  - the incoming config is loaded directly, bypassing the shadow;
  - any older pending config is discarded (cfg_overwrite=1 if the FSM was in PEND);
  - the FSM ends in IDLE.
- ch_cycle_end[i] in IDLE is ignored; ch_load[i] stays 0.
- Active values are written only on ch_load. No arithmetic or clamping: values pass through unchanged, including hlevel > period and period = 0; generators own those cases.
- Channels are independent: loads on multiple channels may occur in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
PWM_UPDATE_SCHED_ERR_CNT_EN
- Defined: adds outputs drop_cnt[15:0] and overwrite_cnt[15:0].
  - Each is a saturating counter (holds at 0xFFFF) that increments on its corresponding pulse.
  - Both reset to 0 asynchronously.
- Undefined: these ports and counters do not exist; the cfg_drop and cfg_overwrite pulses are unchanged.

Test Plan:
1. CH_NUM=4, channel 2 stopped. vld ch=2, en=1, period=1000, hlevel=250 at T -> ch_load[2]=1 at T+1; ch_en[2]=1, ch_period[2]=1000, ch_hlevel[2]=250; cfg_pending stays 0.
2. Channel 2 running. vld ch=2, en=1, period=2000, hlevel=500 -> cfg_pending[2]=1 and actives still 1000/250; pulse ch_cycle_end[2] at C -> ch_load[2]=1 and 2000/500 at C+1, cfg_pending[2]=0.
3. Channel 2 running, PEND with 2000/500. Send 3000/600 before cycle_end -> cfg_overwrite=1; next ch_cycle_end[2] loads 3000/600. Then send en=0 -> immediate load, ch_en[2]=0 at T+1.
4. vld ch=7 with CH_NUM=4 -> cfg_drop=1 for one cycle; all ch_* outputs and cfg_pending unchanged.
5. Channel 1 in PEND. vld ch=1 (4000/100) and ch_cycle_end[1] in the same cycle -> 4000/100 active next cycle, ch_load[1]=1, cfg_pending[1]=0, cfg_overwrite=1.
6. Channel 3 in PEND. Assert rst mid-operation -> all outputs 0 immediately; after release, ch_cycle_end[3] produces no ch_load. With the macro defined, drop_cnt and overwrite_cnt read 0.

Source files
------------

// File: rtl/pwm_update_scheduler.sv
// Per-channel shadow/active register scheduler for PWM generators; parameters reach the active set only at a period boundary.
// Optional build macro PWM_UPDATE_SCHED_ERR_CNT_EN adds saturating drop/overwrite event counters.
module pwm_update_scheduler #(
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwm_config_vld,
    input  logic [7:0]              pwm_config_channel,
    input  logic                    pwm_en,
    input  logic [CNT_W-1:0]        pwm_period,
    input  logic [CNT_W-1:0]        pwm_hlevel,
    input  logic [CH_NUM-1:0]       ch_cycle_end,
    output logic [CH_NUM-1:0]       ch_load,
    output logic [CH_NUM-1:0]       ch_en,
    output logic [CH_NUM*CNT_W-1:0] ch_period,
    output logic [CH_NUM*CNT_W-1:0] ch_hlevel,
    output logic [CH_NUM-1:0]       cfg_pending,
    output logic                    cfg_drop,
    output logic                    cfg_overwrite
`ifdef PWM_UPDATE_SCHED_ERR_CNT_EN
    ,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             overwrite_cnt
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

    localparam logic [7:0] CH_LIM = 8'(CH_NUM);

    state_t            state_r      [CH_NUM];
    state_t            state_next_s [CH_NUM];
    logic [CH_NUM-1:0] hit_s;
    logic [CH_NUM-1:0] direct_s;
    logic [CH_NUM-1:0] from_shadow_s;
    logic [CH_NUM-1:0] load_s;
    logic              overwrite_s;
    logic              drop_s;
    logic [CH_NUM-1:0] sh_en_r;
    logic [CNT_W-1:0]  sh_period_r [CH_NUM];
    logic [CNT_W-1:0]  sh_hlevel_r [CH_NUM];

    // Channel decode; direct covers stopped channel, disable request and same-cycle boundary
    always_comb begin
        drop_s = pwm_config_vld && (pwm_config_channel >= CH_LIM);
        for (int i = 0; i < CH_NUM; i++) begin
            hit_s[i]    = pwm_config_vld && (pwm_config_channel == 8'(i));
            direct_s[i] = hit_s[i] && (!ch_en[i] || !pwm_en || ch_cycle_end[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) state_r[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < CH_NUM; i++) state_r[i] <= state_next_s[i];
        end
    end

    // FSM next-state logic
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            state_next_s[i] = ST_IDLE;
            case (state_r[i])
                ST_IDLE: begin
                    if (hit_s[i] && !direct_s[i]) state_next_s[i] = ST_PEND;
                    else                          state_next_s[i] = ST_IDLE;
                end
                ST_PEND: begin
                    if (ch_cycle_end[i] || direct_s[i]) state_next_s[i] = ST_IDLE;
                    else                                state_next_s[i] = ST_PEND;
                end
                default: state_next_s[i] = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: load source select, overwrite detection, pending flags
    always_comb begin
        overwrite_s = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            from_shadow_s[i] = (state_r[i] == ST_PEND) && ch_cycle_end[i] && !hit_s[i];
            load_s[i]        = direct_s[i] || from_shadow_s[i];
            cfg_pending[i]   = (state_r[i] == ST_PEND);
            if (hit_s[i] && (state_r[i] == ST_PEND)) overwrite_s = 1'b1;
            else                                     overwrite_s = overwrite_s;
        end
    end

    // Shadow capture of every accepted config
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en_r <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                sh_period_r[i] <= '0;
                sh_hlevel_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (hit_s[i]) begin
                    sh_en_r[i]     <= pwm_en;
                    sh_period_r[i] <= pwm_period;
                    sh_hlevel_r[i] <= pwm_hlevel;
                end
            end
        end
    end

    // Active registers and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_load       <= '0;
            ch_en         <= '0;
            ch_period     <= '0;
            ch_hlevel     <= '0;
            cfg_drop      <= 1'b0;
            cfg_overwrite <= 1'b0;
        end else begin
            ch_load       <= load_s;
            cfg_drop      <= drop_s;
            cfg_overwrite <= overwrite_s;
            for (int i = 0; i < CH_NUM; i++) begin
                if (direct_s[i]) begin
                    ch_en[i]                     <= pwm_en;
                    ch_period[i*CNT_W +: CNT_W]  <= pwm_period;
                    ch_hlevel[i*CNT_W +: CNT_W]  <= pwm_hlevel;
                end else if (from_shadow_s[i]) begin
                    ch_en[i]                     <= sh_en_r[i];
                    ch_period[i*CNT_W +: CNT_W]  <= sh_period_r[i];
                    ch_hlevel[i*CNT_W +: CNT_W]  <= sh_hlevel_r[i];
                end
            end
        end
    end

`ifdef PWM_UPDATE_SCHED_ERR_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) return v;
        else               return v + 16'd1;
    endfunction

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt      <= 16'd0;
            overwrite_cnt <= 16'd0;
        end else begin
            if (cfg_drop)      drop_cnt      <= sat_inc(drop_cnt);
            if (cfg_overwrite) overwrite_cnt <= sat_inc(overwrite_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed self-checking bench for pwm_update_scheduler with CH_NUM=4.
module tb_pwm_update_scheduler;

    localparam int CH = 4;
    localparam int CW = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pwm_config_vld = 1'b0;
    logic [7:0]        pwm_config_channel = 8'd0;
    logic              pwm_en = 1'b0;
    logic [CW-1:0]     pwm_period = '0;
    logic [CW-1:0]     pwm_hlevel = '0;
    logic [CH-1:0]     ch_cycle_end = '0;
    logic [CH-1:0]     ch_load;
    logic [CH-1:0]     ch_en;
    logic [CH*CW-1:0]  ch_period;
    logic [CH*CW-1:0]  ch_hlevel;
    logic [CH-1:0]     cfg_pending;
    logic              cfg_drop;
    logic              cfg_overwrite;
`ifdef PWM_UPDATE_SCHED_ERR_CNT_EN
    logic [15:0]       drop_cnt;
    logic [15:0]       overwrite_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_update_scheduler #(.CH_NUM(CH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .pwm_config_vld(pwm_config_vld), .pwm_config_channel(pwm_config_channel),
        .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_hlevel(pwm_hlevel),
        .ch_cycle_end(ch_cycle_end), .ch_load(ch_load), .ch_en(ch_en),
        .ch_period(ch_period), .ch_hlevel(ch_hlevel), .cfg_pending(cfg_pending),
        .cfg_drop(cfg_drop), .cfg_overwrite(cfg_overwrite)
`ifdef PWM_UPDATE_SCHED_ERR_CNT_EN
        , .drop_cnt(drop_cnt), .overwrite_cnt(overwrite_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] per(input int i);
        return ch_period[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] hl(input int i);
        return ch_hlevel[i*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one config strobe for a single cycle; outputs of T+1 are visible on return
    task automatic send(input int ch, input logic en, input int p, input int h, input logic [CH-1:0] ce);
        pwm_config_vld     = 1'b1;
        pwm_config_channel = 8'(ch);
        pwm_en             = en;
        pwm_period         = CW'(p);
        pwm_hlevel         = CW'(h);
        ch_cycle_end       = ce;
        tick();
        pwm_config_vld     = 1'b0;
        ch_cycle_end       = '0;
    endtask

    task automatic cyc_end(input logic [CH-1:0] ce);
        ch_cycle_end = ce;
        tick();
        ch_cycle_end = '0;
    endtask

    initial begin
        tick(); tick();
        check("rst_load", 64'(ch_load), 64'd0);
        check("rst_en", 64'(ch_en), 64'd0);
        check("rst_period", 64'(ch_period[63:0]), 64'd0);
        check("rst_pend", 64'(cfg_pending), 64'd0);
        rst = 1'b0;
        tick();

        // 1: stopped channel applies at once
        send(2, 1'b1, 1000, 250, 4'b0000);
        check("t1_load", 64'(ch_load), 64'b0100);
        check("t1_en", 64'(ch_en), 64'b0100);
        check("t1_per", 64'(per(2)), 64'd1000);
        check("t1_hl", 64'(hl(2)), 64'd250);
        check("t1_pend", 64'(cfg_pending), 64'd0);
        tick();
        check("t1_load_pulse", 64'(ch_load), 64'd0);

        // 2: running channel defers to cycle end
        send(2, 1'b1, 2000, 500, 4'b0000);
        check("t2_pend", 64'(cfg_pending), 64'b0100);
        check("t2_per_hold", 64'(per(2)), 64'd1000);
        check("t2_load0", 64'(ch_load), 64'd0);
        tick();
        check("t2_per_hold2", 64'(per(2)), 64'd1000);
        cyc_end(4'b0100);
        check("t2_load", 64'(ch_load), 64'b0100);
        check("t2_per", 64'(per(2)), 64'd2000);
        check("t2_hl", 64'(hl(2)), 64'd500);
        check("t2_pend_clr", 64'(cfg_pending), 64'd0);

        // 3: overwrite while pending, then immediate disable
        send(2, 1'b1, 2000, 500, 4'b0000);
        check("t3_ovw0", 64'(cfg_overwrite), 64'd0);
        send(2, 1'b1, 3000, 600, 4'b0000);
        check("t3_ovw", 64'(cfg_overwrite), 64'd1);
        check("t3_pend", 64'(cfg_pending), 64'b0100);
        check("t3_per_hold", 64'(per(2)), 64'd2000);
        tick();
        check("t3_ovw_pulse", 64'(cfg_overwrite), 64'd0);
        cyc_end(4'b0100);
        check("t3_per", 64'(per(2)), 64'd3000);
        check("t3_hl", 64'(hl(2)), 64'd600);
        send(2, 1'b0, 3000, 600, 4'b0000);
        check("t3_dis_load", 64'(ch_load), 64'b0100);
        check("t3_dis_en", 64'(ch_en), 64'd0);

        // 4: out-of-range channel dropped
        send(7, 1'b1, 5, 5, 4'b0000);
        check("t4_drop", 64'(cfg_drop), 64'd1);
        check("t4_load", 64'(ch_load), 64'd0);
        check("t4_en", 64'(ch_en), 64'd0);
        check("t4_pend", 64'(cfg_pending), 64'd0);
        check("t4_per", 64'(per(2)), 64'd3000);
        tick();
        check("t4_drop_pulse", 64'(cfg_drop), 64'd0);

        // 5: config and cycle end together while pending
        send(1, 1'b1, 10, 5, 4'b0000);
        send(1, 1'b1, 20, 5, 4'b0000);
        check("t5_pend", 64'(cfg_pending), 64'b0010);
        send(1, 1'b1, 4000, 100, 4'b0010);
        check("t5_load", 64'(ch_load), 64'b0010);
        check("t5_per", 64'(per(1)), 64'd4000);
        check("t5_hl", 64'(hl(1)), 64'd100);
        check("t5_pend_clr", 64'(cfg_pending), 64'd0);
        check("t5_ovw", 64'(cfg_overwrite), 64'd1);

        // cycle end in IDLE ignored; values pass through unclamped
        cyc_end(4'b1111);
        check("idle_ce_load", 64'(ch_load), 64'd0);
        send(0, 1'b1, 0, 9, 4'b0000);
        check("pass_per0", 64'(per(0)), 64'd0);
        check("pass_hl", 64'(hl(0)), 64'd9);

        // 6: asynchronous reset with channel 3 pending
        send(3, 1'b1, 50, 25, 4'b0000);
        send(3, 1'b1, 60, 30, 4'b0000);
        check("t6_pend", 64'(cfg_pending), 64'b1000);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_en", 64'(ch_en), 64'd0);
        check("t6_rst_pend", 64'(cfg_pending), 64'd0);
        check("t6_rst_per", 64'(per(3)), 64'd0);
        check("t6_rst_hl", 64'(hl(1)), 64'd0);
`ifdef PWM_UPDATE_SCHED_ERR_CNT_EN
        check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t6_ovw_cnt", 64'(overwrite_cnt), 64'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        cyc_end(4'b1000);
        check("t6_no_load", 64'(ch_load), 64'd0);
        check("t6_per_after", 64'(per(3)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
